// File: rtl/mfp_seven_segment_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous shadow latching.
// Optional leading-zero blanking is enabled by defining MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module mfp_seven_segment_scanner #(
   parameter int unsigned N_DIGITS          = 8,
   parameter int unsigned DIGIT_PERIOD_LOG2 = 16,
   parameter int unsigned BLANK_CYCLES      = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [4*N_DIGITS-1:0] number,
   input  logic [N_DIGITS-1:0]   dots,
   output logic [N_DIGITS-1:0]   anodes,
   output logic [6:0]            segments,
   output logic                  dot,
   output logic                  frame_start
);

   localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IW-1:0] LAST_DIGIT = IW'(N_DIGITS - 1);

   logic [DIGIT_PERIOD_LOG2-1:0] r_presc, w_presc;
   logic [IW-1:0]                r_index, w_index;
   logic [4*N_DIGITS-1:0]        r_shadow_num;
   logic [N_DIGITS-1:0]          r_shadow_dots;
   logic [N_DIGITS-1:0]          r_anodes, w_anodes;
   logic [6:0]                   r_segments, w_segments;
   logic                         r_dot, w_dot;
   logic                         r_frame_start;
   logic                         w_slot_end, w_frame_end, w_blank, w_dot_req;
   logic [3:0]                   w_nibble;
`ifdef MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN
   logic                         w_hi_zero;
`endif

   function automatic logic [6:0] f_decode(input logic [3:0] hex);
      logic [6:0] seg;
      unique case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   always_comb begin
      w_slot_end  = &r_presc;
      w_frame_end = w_slot_end && (r_index == LAST_DIGIT);
      w_presc     = r_presc + DIGIT_PERIOD_LOG2'(1);
      w_index     = r_index;
      if (w_slot_end) begin
         w_index = (r_index == LAST_DIGIT) ? '0 : r_index + IW'(1);
      end

      w_nibble  = 4'h0;
      w_dot_req = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_index == IW'(i)) begin
            w_nibble  = r_shadow_num[4*i +: 4];
            w_dot_req = r_shadow_dots[i];
         end
      end

      w_blank = (32'(r_presc) < BLANK_CYCLES);
`ifdef MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN
      // Digit is a leading zero when it and every more-significant nibble are zero.
      w_hi_zero = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if ((IW'(i) >= r_index) && (r_shadow_num[4*i +: 4] != 4'h0)) begin
            w_hi_zero = 1'b0;
         end
      end
      if ((r_index != '0) && w_hi_zero && !w_dot_req) begin
         w_blank = 1'b1;
      end
`endif

      w_anodes   = '1;
      w_segments = 7'h7F;
      w_dot      = 1'b1;
      if (!w_blank) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            w_anodes[i] = (r_index != IW'(i));
         end
         w_segments = f_decode(w_nibble);
         w_dot      = ~w_dot_req;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_presc       <= '0;
         r_index       <= '0;
         r_shadow_num  <= '0;
         r_shadow_dots <= '0;
         r_anodes      <= '1;
         r_segments    <= 7'h7F;
         r_dot         <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_presc       <= w_presc;
         r_index       <= w_index;
         r_anodes      <= w_anodes;
         r_segments    <= w_segments;
         r_dot         <= w_dot;
         r_frame_start <= w_frame_end;
         if (w_frame_end) begin
            r_shadow_num  <= number;
            r_shadow_dots <= dots;
         end
      end
   end

   assign anodes      = r_anodes;
   assign segments    = r_segments;
   assign dot         = r_dot;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_mfp_seven_segment_scanner.sv
// Randomized self-checking bench for mfp_seven_segment_scanner (N_DIGITS=4, 16-cycle slots,
// 2 blank cycles) against a cycle-count reference model plus directed literal checks.
module tb_mfp_seven_segment_scanner;

   localparam logic [12:0] RST_OUT = {4'hF, 7'h7F, 1'b1, 1'b0};

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [15:0] number;
   logic [3:0]  dots;
   logic [3:0]  anodes;
   logic [6:0]  segments;
   logic        dot;
   logic        frame_start;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          c;
   logic [15:0] shn;
   logic [3:0]  shd;
   logic [12:0] exp_out;
   logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   mfp_seven_segment_scanner #(
      .N_DIGITS          (4),
      .DIGIT_PERIOD_LOG2 (4),
      .BLANK_CYCLES      (2)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .number      (number),
      .dots        (dots),
      .anodes      (anodes),
      .segments    (segments),
      .dot         (dot),
      .frame_start (frame_start)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs after the edge that leaves state "c cycles since reset release".
   function automatic logic [12:0] model_out(input int cyc, input logic [15:0] n,
                                             input logic [3:0] d);
      int         p;
      int         k;
      logic       blank;
      logic [3:0] an;
      logic [6:0] sg;
      logic       dt;
      logic [15:0] hi;
      p     = cyc % 16;
      k     = (cyc / 16) % 4;
      blank = (p < 2);
      hi    = n >> (4 * k);
`ifdef MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (k > 0 && hi == 16'h0 && !d[k]) blank = 1'b1;
`endif
      an = 4'hF;
      sg = 7'h7F;
      dt = 1'b1;
      if (!blank) begin
         an = ~(4'b0001 << k);
         sg = seg_tbl[hi[3:0]];
         dt = ~d[k];
      end
      return {an, sg, dt, (cyc % 64) == 63};
   endfunction

   function automatic int digit_of(input logic [3:0] an);
      int k;
      k = -1;
      for (int i = 0; i < 4; i++) if (!an[i]) k = i;
      return k;
   endfunction

   task automatic tick();
      if (!HRESETn) begin
         exp_out = RST_OUT;
         c       = 0;
         shn     = '0;
         shd     = '0;
      end else begin
         exp_out = model_out(c, shn, shd);
         if (c % 64 == 63) begin
            shn = number;
            shd = dots;
         end
         c++;
      end
      @(posedge HCLK);
      @(negedge HCLK);
      check("scan", 32'({anodes, segments, dot, frame_start}), 32'(exp_out));
      check("onehot", 32'($countones(~anodes) <= 1), 32'd1);
   endtask

   task automatic wait_frame(input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         tick();
         found = frame_start;
      end
      if (!found) check(tag, 32'd0, 32'd1);
   endtask

   initial begin
      int         cnt;
      int         drv [4];
      int         k;
      logic [3:0] lit_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
      logic [6:0] lit_sg [4] = '{7'h40, 7'h0E, 7'h12, 7'h08};
      logic [3:0] first_an;

      HRESETn = 1'b0;
      number  = 16'h1234;
      dots    = 4'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_hold", 32'({anodes, segments, dot, frame_start}), 32'(RST_OUT));
      end

      // First frame_start and literal scan order in the second frame.
      HRESETn = 1'b1;
      number  = 16'hA5F0;
      dots    = 4'b0010;
      cnt     = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         cnt++;
         if (frame_start) break;
      end
      check("first_fs", 32'(cnt), 32'd64);
      drv = '{0, 0, 0, 0};
      for (int j = 0; j < 64; j++) begin
         tick();
         k = j / 16;
         if (anodes != 4'hF) drv[k]++;
         if (j % 16 >= 2) begin
            check("order_an", 32'(anodes), 32'(lit_an[k]));
            check("order_sg", 32'(segments), 32'(lit_sg[k]));
            check("order_dot", 32'(dot), 32'(k != 1));
         end
      end
      for (int i = 0; i < 4; i++) check("drive_len", 32'(drv[i]), 32'd14);

      // Tear-free update.
      number = 16'h1111;
      dots   = 4'h0;
      wait_frame("tear_fs1");
      for (int i = 0; i < 24; i++) tick();
      number = 16'h2222;
      wait_frame("tear_fs2");
      for (int j = 0; j < 64; j++) begin
         tick();
         if (anodes != 4'hF) check("tear_new", 32'(segments), 32'h24);
      end

      // Reset mid-frame during digit 2 drive.
      number = 16'h8888;
      wait_frame("rmid_fs");
      cnt = 0;
      while (anodes != 4'hB && cnt < 80) begin
         tick();
         cnt++;
      end
      if (cnt >= 80) check("rmid_reach", 32'd0, 32'd1);
      HRESETn = 1'b0;
      tick();
      check("rmid_rst", 32'({anodes, segments, dot, frame_start}), 32'(RST_OUT));
      HRESETn  = 1'b1;
      first_an = 4'hF;
      for (int j = 0; j < 64; j++) begin
         tick();
         if (anodes != 4'hF) begin
            if (first_an == 4'hF) first_an = anodes;
            check("rmid_zero", 32'(segments), 32'h40);
         end
      end
      check("rmid_first", 32'(first_an), 32'hE);

      // Leading zeros.
      number = 16'h0007;
      dots   = 4'h0;
      wait_frame("lz_fs");
      for (int j = 0; j < 64; j++) begin
         tick();
         if (anodes != 4'hF) begin
            k = digit_of(anodes);
`ifdef MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN
            check("lz_digit", 32'(k), 32'd0);
            check("lz_seg", 32'(segments), 32'h78);
`else
            check("lz_seg", 32'(segments), (k == 0) ? 32'h78 : 32'h40);
`endif
         end
      end

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            number = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dots   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         end
         HRESETn = ($urandom_range(0, 499) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mfp_seven_segment_scanner.md
# mfp_seven_segment_scanner

Time-multiplexed driver for a common-anode multi-digit 7-segment display, downstream of the GPIO slave. Consumes the packed hex value that the slave holds in its 7-segment register (one nibble per digit) and drives one digit at a time. It provides:
- hex-to-segment decoding;
- frame-synchronous latching of the value, so a digit never tears mid-frame;
- anti-ghosting blanking at every digit switch.

## Interface

Parameters:
- N_DIGITS, 8, number of digits; width of `number` is 4*N_DIGITS.
- DIGIT_PERIOD_LOG2, 16, each digit slot lasts 2^DIGIT_PERIOD_LOG2 HCLK cycles.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < 2^DIGIT_PERIOD_LOG2.

Ports:
- HCLK  in  1  clock; single clock domain.
- HRESETn  in  1  reset, synchronous, active-low.
- number  in  4*N_DIGITS  hex value; nibble i belongs to digit i (digit 0 = rightmost).
- dots  in  N_DIGITS  decimal point request per digit, active-high.
- anodes  out  N_DIGITS  digit enables, active-low, registered.
- segments  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- dot  out  1  decimal point, active-low, registered.
- frame_start  out  1  one-cycle pulse, registered, asserted when the shadow register loads.

## Operation

- Prescaler: DIGIT_PERIOD_LOG2-bit counter, increments every cycle and wraps from all-ones to 0.
- Digit index: counter 0..N_DIGITS-1. Advances on the prescaler wrap; wraps from N_DIGITS-1 to 0. N_DIGITS need not be a power of two.
- Shadow register: {number, dots} is loaded on the cycle where prescaler = all-ones and index = N_DIGITS-1.
  - Decoding uses only the shadow register; changes to `number`/`dots` mid-frame are invisible until the next frame.
- Slot phases:
  - Blank phase, prescaler < BLANK_CYCLES: anodes all ones, segments 7'h7F, dot 1.
  - Drive phase: anodes = ~(1 << index); segments = decode(shadow nibble[index]); dot = ~shadow_dots[index].
- Decode, standard hex, active-low: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- Reset (HRESETn low at a rising edge):
  - prescaler, index, shadow and frame_start all 0;
  - anodes all ones, segments 7'h7F, dot 1.
  - Reset takes priority over every other update.
  - Reset asserted mid-slot or mid-frame aborts that frame; no partial state survives.
- First frame after reset displays the reset shadow value (zeros, or blank under the configuration macro).
- BLANK_CYCLES = 0: no blank phase; the anodes switch directly between digits.

## Timing

- All outputs are registered. The outputs in a cycle reflect the prescaler/index/shadow values of the previous cycle.
- Drive phase for slot i: asserted from cycle BLANK_CYCLES+1 through cycle 2^DIGIT_PERIOD_LOG2 of the slot, counted from the prescaler = 0 cycle. Released one cycle after the prescaler wraps.
- frame_start: asserted in the cycle after the shadow load, i.e. the same cycle in which the index reads 0 and the prescaler reads 0.
- Frame period: N_DIGITS × 2^DIGIT_PERIOD_LOG2 cycles. At most one anode is ever low.

## Configuration

- MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN defined:
  - A digit i > 0 is treated as in the blank phase for its whole slot when shadow nibbles i..N_DIGITS-1 are all zero and shadow_dots[i] = 0.
  - Digit 0 is always driven.
  - Blanking is computed from the shadow register only.
- Macro undefined: every digit is driven in every slot, including leading zeros.

## Test plan

Bench parameters: N_DIGITS=4, DIGIT_PERIOD_LOG2=4, BLANK_CYCLES=2.
- Reset: hold HRESETn low 3 cycles with number=16'h1234 → anodes=4'hF, segments=7'h7F, dot=1, frame_start=0 throughout; after release, first frame_start 64 cycles later.
- Scan order: number=16'hA5F0, dots=4'b0010 after reset, observed in the second frame:
  - digit 0: anodes=4'hE, segments=7'h40;
  - digit 1: anodes=4'hD, segments=7'h0E, dot=0;
  - digit 2: anodes=4'hB, segments=7'h12;
  - digit 3: anodes=4'h7, segments=7'h08;
  - each digit driven 14 cycles, blanked 2 cycles.
- Tear-free update: change number from 16'h1111 to 16'h2222 while digit 1 is driven → digits 1..3 still show 7'h79 in this frame; every digit shows 7'h24 only after the next frame_start.
- Reset mid-frame: assert HRESETn low during digit 2's drive phase → next cycle all outputs are at reset values; after release, scanning restarts at digit 0 and shows zeros (macro off).
- Leading-zero blanking, macro defined: number=16'h0007, dots=0 → digits 3..1 anodes stay 4'hF for their whole slots; digit 0 shows 7'h78. number=16'h0000 → digit 0 shows 7'h40.
- Leading-zero blanking, macro undefined: number=16'h0007, dots=0 → digits 3..1 show 7'h40.
